wb_slot_mux: RTL and testbench
==============================

WB_SLOT_MUX -- requirements
Module: wb_slot_mux

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, giving the number of user design slots (2..16).
REQ-002 SHALL have parameter IO_WIDTH, default 38, giving the pad count per slot (33..64).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the Wishbone base; bits [7:0] are ignored.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control.
REQ-007 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte lanes, address, write data.
REQ-008 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge, read data.
REQ-009 SHALL have ports io_in  in  IO_WIDTH, io_out  out  IO_WIDTH, io_oeb  out  IO_WIDTH  pad side.
REQ-010 SHALL have ports slot_io_in  out  NUM_SLOTS*IO_WIDTH, slot_io_out  in  NUM_SLOTS*IO_WIDTH, slot_io_oeb  in  NUM_SLOTS*IO_WIDTH  slot side, slot k at bits [k*IO_WIDTH +: IO_WIDTH].
REQ-011 SHALL have port slot_rst  out  NUM_SLOTS  per-slot active-high reset.
REQ-012 SHALL have port irq  out  3  irq[0] edge interrupt, irq[1] switch-done pulse, irq[2] tied 0.

Function
REQ-013 SHALL decode a hit when cyc&stb and adr[31:8]==BASE_ADDR[31:8]; non-hits are never acknowledged.
REQ-014 SHALL assert wbs_ack_o for exactly one cycle, registered one cycle after a hit, and hold it low for the cycle following any ack.
REQ-015 SHALL honour wbs_sel_i per byte on writes; reads return full words.
REQ-016 SHALL map offsets: 0x00 SEL[3:0] rw, 0x04 CTRL rw (bit0 EN, bit1 BUSY ro), 0x08/0x0C MASK lo/hi rw, 0x10/0x14 STATUS lo/hi W1C, 0x18 INFO ro = {IO_WIDTH[7:0], NUM_SLOTS[7:0], 16'h5A01}; other offsets ack with data 0, writes ignored.
REQ-017 SHALL ignore SEL writes with value >= NUM_SLOTS or while BUSY=1 (still acked).
REQ-018 SHALL run a switch FSM: IDLE -> on accepted SEL write with new value != current: DRAIN (1 cycle, io_oeb all 1) -> RESET (4 cycles, slot_rst[new]=1, io_oeb all 1) -> IDLE with cur_slot=new and irq[1] high for one cycle.
REQ-019 SHALL treat a SEL write equal to current slot as a no-op (no FSM activity, no irq[1]).
REQ-020 SHALL drive io_out=slot_io_out[cur_slot], io_oeb=slot_io_oeb[cur_slot] when IDLE and EN=1; otherwise io_out=0, io_oeb all 1.
REQ-021 SHALL route io_in to slot_io_in[cur_slot] only; all other slots see 0.
REQ-022 SHALL hold slot_rst[k]=1 for every k != cur_slot, and slot_rst[cur_slot]=0 outside RESET.
REQ-023 SHALL pass io_in through a 2-flop synchroniser, set STATUS[i] on a synchronised rising edge, clear on W1C; simultaneous set and clear SHALL leave the bit set.
REQ-024 SHALL drive irq[0] = |(STATUS & MASK), registered; MASK and STATUS bits above IO_WIDTH read 0.

Reset
REQ-025 SHALL, on wb_rst_i, immediately force: cur_slot=0, SEL=0, EN=0, MASK=0, STATUS=0, FSM=IDLE, synchronisers=0, wbs_ack_o=0, wbs_dat_o=0, irq=0, slot_rst all 1, io_out=0, io_oeb all 1.
REQ-026 SHALL abandon any in-progress switch on reset; after release slot_rst[0] deasserts on the first clock edge.

Structure
REQ-027 SHALL place register offsets, INFO constant and FSM state enum in shared package wb_slot_mux_pkg.
REQ-028 SHALL implement the Wishbone register file as sub-module wb_slot_mux_regs; muxing, FSM and edge logic remain in the top.

Verification
REQ-029 SHALL cover: reset, read 0x18 with defaults -> 0x2604_5A01, ack exactly one cycle.
REQ-030 SHALL cover: EN=1, write SEL=2 -> BUSY=1, io_oeb all 1 for 5 cycles, slot_rst[2]=1 for 4 cycles, irq[1] pulse, then io_out=slot_io_out[2].
REQ-031 SHALL cover: write SEL=7 (NUM_SLOTS=4) and SEL during BUSY -> acked, cur_slot unchanged.
REQ-032 SHALL cover: MASK lo=0x1, rising io_in[0] -> STATUS lo=0x1 three cycles later, irq[0]=1; W1C 0x1 -> irq[0]=0; W1C coincident with new edge -> bit stays 1.
REQ-033 SHALL cover: wb_rst_i asserted mid-RESET state -> outputs at REQ-025 values same cycle, cur_slot=0 after release.
REQ-034 SHALL cover: access with adr[31:8] mismatched -> no ack; offset 0x40 read -> ack, data 0.

Source files
------------

// File: rtl/wb_slot_mux_pkg.sv
// Shared definitions for the Wishbone slot multiplexer:
// register map, ID constant and switch-FSM states.
package wb_slot_mux_pkg;

  localparam logic [7:0] OFF_SEL   = 8'h00;
  localparam logic [7:0] OFF_CTRL  = 8'h04;
  localparam logic [7:0] OFF_MASKL = 8'h08;
  localparam logic [7:0] OFF_MASKH = 8'h0C;
  localparam logic [7:0] OFF_STATL = 8'h10;
  localparam logic [7:0] OFF_STATH = 8'h14;
  localparam logic [7:0] OFF_INFO  = 8'h18;

  localparam logic [15:0] INFO_ID = 16'h5A01;
  localparam int RST_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RESET
  } sw_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_slot_mux_regs.sv
// Wishbone classic register file: SEL, CTRL, MASK, STATUS (W1C), INFO.
// Single-cycle registered ack with one idle cycle after every ack.
module wb_slot_mux_regs
  import wb_slot_mux_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          IO_WIDTH  = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic [31:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic                ack_o,
  output logic [31:0]         dat_o,
  input  logic                busy_i,
  input  logic [IO_WIDTH-1:0] stat_set_i,
  output logic                en_o,
  output logic                sel_wr_o,
  output logic [3:0]          sel_val_o,
  output logic [IO_WIDTH-1:0] mask_o,
  output logic [IO_WIDTH-1:0] stat_o
);

  localparam logic [63:0] VMASK =
    (IO_WIDTH >= 64) ? '1 : ((64'd1 << IO_WIDTH) - 64'd1);

  logic        ack_q;
  logic        en_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [63:0] mask_q, mask_d;
  logic [63:0] stat_q, stat_d;
  logic [63:0] clr;
  logic [31:0] bm, rdata;
  logic        hit, wr, rd;

  assign hit = cyc_i & stb_i & ~ack_q
             & (adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr  = hit & we_i;
  assign rd  = hit & ~we_i;
  assign bm  = byte_mask(sel_i);

  assign sel_wr_o  = wr & (adr_i[7:0] == OFF_SEL) & sel_i[0]
                   & ~busy_i & (dat_i < 32'(NUM_SLOTS));
  assign sel_val_o = dat_i[3:0];

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr) begin
      case (adr_i[7:0])
        OFF_MASKL: mask_d[31:0]  = (mask_q[31:0] & ~bm) | (dat_i & bm);
        OFF_MASKH: mask_d[63:32] = (mask_q[63:32] & ~bm) | (dat_i & bm);
        OFF_STATL: clr[31:0]     = dat_i & bm;
        OFF_STATH: clr[63:32]    = dat_i & bm;
        default: ;
      endcase
    end
    mask_d = mask_d & VMASK;
    // a fresh edge wins over a coincident clear
    stat_d = ((stat_q & ~clr) | 64'(stat_set_i)) & VMASK;
  end

  always_comb begin
    case (adr_i[7:0])
      OFF_SEL:   rdata = {28'd0, sel_q};
      OFF_CTRL:  rdata = {30'd0, busy_i, en_q};
      OFF_MASKL: rdata = mask_q[31:0];
      OFF_MASKH: rdata = mask_q[63:32];
      OFF_STATL: rdata = stat_q[31:0];
      OFF_STATH: rdata = stat_q[63:32];
      OFF_INFO:  rdata = {8'(IO_WIDTH), 8'(NUM_SLOTS), INFO_ID};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      en_q   <= 1'b0;
      sel_q  <= '0;
      mask_q <= '0;
      stat_q <= '0;
    end else begin
      ack_q  <= hit;
      dat_q  <= rd ? rdata : '0;
      mask_q <= mask_d;
      stat_q <= stat_d;
      if (sel_wr_o)
        sel_q <= dat_i[3:0];
      if (wr && adr_i[7:0] == OFF_CTRL && sel_i[0])
        en_q <= dat_i[0];
    end
  end

  assign ack_o  = ack_q;
  assign dat_o  = dat_q;
  assign en_o   = en_q;
  assign mask_o = mask_q[IO_WIDTH-1:0];
  assign stat_o = stat_q[IO_WIDTH-1:0];

endmodule

// File: rtl/wb_slot_mux.sv
// Pad multiplexer for user design slots: Wishbone-controlled slot
// switching with drain/reset sequencing and synchronised edge IRQs.
module wb_slot_mux
  import wb_slot_mux_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          IO_WIDTH  = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [IO_WIDTH-1:0]           io_in,
  output logic [IO_WIDTH-1:0]           io_out,
  output logic [IO_WIDTH-1:0]           io_oeb,
  output logic [NUM_SLOTS*IO_WIDTH-1:0] slot_io_in,
  input  logic [NUM_SLOTS*IO_WIDTH-1:0] slot_io_out,
  input  logic [NUM_SLOTS*IO_WIDTH-1:0] slot_io_oeb,
  output logic [NUM_SLOTS-1:0]          slot_rst,
  output logic [2:0]                    irq
);

  sw_state_e           state_q;
  logic [3:0]          cur_q, tgt_q;
  logic [1:0]          cnt_q;
  logic                irq0_q, irq1_q;
  logic [NUM_SLOTS-1:0] slot_rst_q, cur_oh;
  logic [IO_WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [IO_WIDTH-1:0] mask, stat, stat_set;
  logic                en, busy, sel_wr;
  logic [3:0]          sel_val;

  assign busy   = (state_q != ST_IDLE);
  assign cur_oh = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << cur_q;

  wb_slot_mux_regs #(
    .NUM_SLOTS(NUM_SLOTS),
    .IO_WIDTH (IO_WIDTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_regs (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .cyc_i     (wbs_cyc_i),
    .stb_i     (wbs_stb_i),
    .we_i      (wbs_we_i),
    .sel_i     (wbs_sel_i),
    .adr_i     (wbs_adr_i),
    .dat_i     (wbs_dat_i),
    .ack_o     (wbs_ack_o),
    .dat_o     (wbs_dat_o),
    .busy_i    (busy),
    .stat_set_i(stat_set),
    .en_o      (en),
    .sel_wr_o  (sel_wr),
    .sel_val_o (sel_val),
    .mask_o    (mask),
    .stat_o    (stat)
  );

  // s1/s2 synchronise, s3 is history for edge detection
  assign stat_set = s2_q & ~s3_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      irq0_q <= 1'b0;
    end else begin
      s1_q   <= io_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      irq0_q <= |(stat & mask);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      irq1_q     <= 1'b0;
      slot_rst_q <= '1;
    end else begin
      irq1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          slot_rst_q <= ~cur_oh;
          if (sel_wr && sel_val != cur_q) begin
            tgt_q   <= sel_val;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_RESET;
          cur_q      <= tgt_q;
          cnt_q      <= '0;
          slot_rst_q <= '1;
        end
        ST_RESET: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'(RST_CYCLES - 1)) begin
            state_q    <= ST_IDLE;
            irq1_q     <= 1'b1;
            slot_rst_q <= ~cur_oh;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    slot_io_in = '0;
    slot_io_in[int'(cur_q)*IO_WIDTH +: IO_WIDTH] = io_in;
    if (!busy && en) begin
      io_out = slot_io_out[int'(cur_q)*IO_WIDTH +: IO_WIDTH];
      io_oeb = slot_io_oeb[int'(cur_q)*IO_WIDTH +: IO_WIDTH];
    end
  end

  assign slot_rst = slot_rst_q;
  assign irq      = {1'b0, irq1_q, irq0_q};

endmodule

// File: tb/tb_wb_slot_mux.sv
// Self-checking bench for wb_slot_mux: read data goes through a
// scoreboard queue, pad/reset/irq behaviour is checked directly.
module tb_wb_slot_mux;

  localparam int NS = 4;
  localparam int IW = 38;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [IW-1:0]     io_in, io_out, io_oeb;
  logic [NS*IW-1:0]  slot_io_in, slot_io_out, slot_io_oeb;
  logic [NS-1:0]     slot_rst;
  logic [2:0]        irq;

  logic [IW-1:0] s_out [NS];
  logic [IW-1:0] s_oeb [NS];
  logic [31:0]   exp_q [$];
  int checks = 0;
  int errors = 0;
  int oeb_cnt, rstall_cnt, irq1_cnt;
  bit mon = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_slot_mux dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .slot_io_in (slot_io_in),
    .slot_io_out(slot_io_out),
    .slot_io_oeb(slot_io_oeb),
    .slot_rst   (slot_rst),
    .irq        (irq)
  );

  always @(negedge wb_clk_i) begin
    if (mon) begin
      if (&io_oeb)   oeb_cnt++;
      if (&slot_rst) rstall_cnt++;
      if (irq[1])    irq1_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output logic ok, output logic [31:0] rd);
    ok = 1'b0;
    rd = '0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        ok = 1'b1;
        rd = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (ok) begin
      @(posedge wb_clk_i); #1;
      chk("ack_one_cycle", wbs_ack_o, 0);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic ok;
    logic [31:0] rd;
    wb_xfer(1'b1, adr, dat, sel, ok, rd);
    chk("wr_ack", ok, 1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] adr,
                         input logic [31:0] exp);
    logic ok;
    logic [31:0] rd, e;
    exp_q.push_back(exp);
    wb_xfer(1'b0, adr, 32'd0, 4'hF, ok, rd);
    e = exp_q.pop_front();
    if (ok) chk(tag, rd, e);
    else    chk({tag, "_ack"}, ok, 1);
  endtask

  localparam logic [31:0] B = 32'h3000_0000;

  initial begin
    logic ok;
    logic [31:0] rd;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    io_in = '0;
    for (int k = 0; k < NS; k++) begin
      s_out[k] = {6'(k + 1), 32'hC0DE_0000 | 32'(k)};
      s_oeb[k] = {6'(k), 32'h0F0F_0000 | 32'(k)};
      slot_io_out[k*IW +: IW] = s_out[k];
      slot_io_oeb[k*IW +: IW] = s_oeb[k];
    end
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_oeb", io_oeb, {IW{1'b1}});
    chk("rst_out", io_out, 0);
    chk("rst_slot_rst", slot_rst, 4'hF);
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_irq", irq, 0);

    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("rel_slot_rst", slot_rst, 4'hE);

    wb_read("info", B + 32'h18, 32'h2604_5A01);
    wb_read("sel0", B + 32'h00, 32'd0);
    wb_read("ctrl0", B + 32'h04, 32'd0);

    wb_write(B + 32'h04, 32'd1, 4'hF);
    chk("en_out0", io_out, s_out[0]);
    chk("en_oeb0", io_oeb, s_oeb[0]);

    oeb_cnt = 0; rstall_cnt = 0; irq1_cnt = 0; mon = 1'b1;
    wb_write(B + 32'h00, 32'd2, 4'hF);
    repeat (10) @(negedge wb_clk_i);
    mon = 1'b0;
    chk("sw_oeb_cycles", oeb_cnt, 5);
    chk("sw_rst_cycles", rstall_cnt, 4);
    chk("sw_irq1_pulse", irq1_cnt, 1);
    chk("sw_out2", io_out, s_out[2]);
    chk("sw_oeb2", io_oeb, s_oeb[2]);
    chk("sw_slot_rst2", slot_rst, 4'hB);
    wb_read("sel2", B + 32'h00, 32'd2);

    irq1_cnt = 0; mon = 1'b1;
    wb_write(B + 32'h00, 32'd1, 4'hF);
    wb_write(B + 32'h00, 32'd3, 4'hF);
    wb_read("ctrl_busy", B + 32'h04, 32'd3);
    repeat (12) @(negedge wb_clk_i);
    mon = 1'b0;
    chk("busy_irq1", irq1_cnt, 1);
    chk("busy_out1", io_out, s_out[1]);
    wb_read("sel_busy", B + 32'h00, 32'd1);

    irq1_cnt = 0; mon = 1'b1;
    wb_write(B + 32'h00, 32'd7, 4'hF);
    wb_write(B + 32'h00, 32'd1, 4'hF);
    wb_write(B + 32'h00, 32'd0, 4'hE);
    wb_read("ctrl_idle", B + 32'h04, 32'd1);
    repeat (8) @(negedge wb_clk_i);
    mon = 1'b0;
    chk("noop_irq1", irq1_cnt, 0);
    chk("noop_out1", io_out, s_out[1]);
    wb_read("sel_keep", B + 32'h00, 32'd1);

    wb_write(B + 32'h0C, 32'hFFFF_FFFF, 4'h1);
    wb_read("maskh_clip", B + 32'h0C, 32'h0000_003F);
    wb_write(B + 32'h0C, 32'd0, 4'hF);
    wb_write(B + 32'h08, 32'd1, 4'hF);

    @(negedge wb_clk_i) io_in = 38'h1;
    repeat (4) @(posedge wb_clk_i);
    #1;
    chk("edge_irq0", irq[0], 1);
    chk("slot_in_cur", slot_io_in[IW +: IW], io_in);
    chk("slot_in_oth", (|slot_io_in[IW-1:0]) | (|slot_io_in[NS*IW-1:2*IW]), 0);
    wb_read("stat_lo", B + 32'h10, 32'd1);
    wb_read("stat_hi", B + 32'h14, 32'd0);
    wb_write(B + 32'h10, 32'd1, 4'hF);
    chk("w1c_irq0", irq[0], 0);
    wb_read("stat_clr", B + 32'h10, 32'd0);

    @(negedge wb_clk_i) io_in = '0;
    repeat (5) @(negedge wb_clk_i);
    io_in = 38'h1;
    @(negedge wb_clk_i);
    wb_write(B + 32'h10, 32'd1, 4'hF);
    wb_read("stat_race", B + 32'h10, 32'd1);

    wb_write(B + 32'h00, 32'd3, 4'hF);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("mid_oeb", io_oeb, {IW{1'b1}});
    chk("mid_out", io_out, 0);
    chk("mid_slot_rst", slot_rst, 4'hF);
    chk("mid_irq", irq, 0);
    chk("mid_ack", wbs_ack_o, 0);
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("mid_rel_slot_rst", slot_rst, 4'hE);
    wb_read("mid_sel", B + 32'h00, 32'd0);
    wb_read("mid_ctrl", B + 32'h04, 32'd0);

    wb_xfer(1'b0, 32'h3000_0118, 32'd0, 4'hF, ok, rd);
    chk("miss_rd_noack", ok, 0);
    wb_xfer(1'b1, 32'h3100_0004, 32'd1, 4'hF, ok, rd);
    chk("miss_wr_noack", ok, 0);
    wb_read("miss_ctrl", B + 32'h04, 32'd0);
    wb_write(B + 32'h40, 32'hFFFF_FFFF, 4'hF);
    wb_read("off40", B + 32'h40, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
